// File: rtl/ahb3lite_ifetch.sv
// AHB3-Lite instruction fetch master feeding a DEPTH-entry prefetch FIFO.
// state | meaning
// RUN   | fetching, address phases issued while credit remains
// HOLD  | credit exhausted, HTRANS held IDLE
// ERR   | bus error returned, fetching stopped until flush_i
module ahb3lite_ifetch #(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [HADDR_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  flush_i,
    input  logic [HADDR_SIZE-1:0] flush_pc_i,
    output logic [HDATA_SIZE-1:0] inst_o,
    output logic [HADDR_SIZE-1:0] inst_pc_o,
    output logic                  inst_err_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [HADDR_SIZE-1:0] BYTES = HADDR_SIZE'(HDATA_SIZE / 8);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {RUN, HOLD, ERR} state_t;

    state_t                  state;
    logic [1:0]              htrans_q;
    logic [HADDR_SIZE-1:0]   haddr_q, next_pc, flush_pc, d_pc, tgt_pc;
    logic                    flush_pend, d_valid, d_disc;
    logic [HDATA_SIZE-1:0]   mem_data [DEPTH];
    logic [HADDR_SIZE-1:0]   mem_pc   [DEPTH];
    logic                    mem_err  [DEPTH];
    logic [PW-1:0]           wptr, rptr;
    logic [CW-1:0]           count, count_n;
    logic [CW:0]             inflight;
    logic                    pop, a_valid, redirect, wr, wr_err, err_first;
    logic                    d_valid_n, credit, issue, nonseq_n;

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = 1'b0;
    assign HSIZE  = 3'($clog2(HDATA_SIZE / 8));
    assign HBURST = 3'b001;
    assign HPROT  = 4'b0000;
    assign HWDATA = '0;

    assign inst_valid_o = (count != '0);
    assign inst_o       = mem_data[rptr];
    assign inst_pc_o    = mem_pc[rptr];
    assign inst_err_o   = inst_valid_o && mem_err[rptr];

    assign pop       = inst_valid_o && inst_ready_i;
    assign a_valid   = htrans_q[1];
    assign redirect  = flush_i || flush_pend;
    assign tgt_pc    = flush_i ? flush_pc_i : (flush_pend ? flush_pc : next_pc);
    assign wr        = HREADY && d_valid && !d_disc && !flush_i;
    assign wr_err    = wr && HRESP;
    // First cycle of the two-cycle ERROR response: cancel the pending address.
    assign err_first = !HREADY && d_valid && !d_disc && HRESP && !flush_i;
    assign d_valid_n = HREADY ? a_valid : d_valid;
    assign count_n   = flush_i ? '0 : count + CW'(wr) - CW'(pop);
    assign inflight  = {1'b0, count_n} + (CW+1)'(d_valid_n);
    assign credit    = inflight < (CW+1)'(DEPTH);
    assign issue     = HREADY && credit && !wr_err && (state != ERR || flush_i);
    assign nonseq_n  = redirect || !a_valid || (tgt_pc[9:0] == 10'd0);

    always_ff @(posedge HCLK) begin
        if (wr) begin
            mem_data[wptr] <= HRESP ? '0 : HRDATA;
            mem_pc[wptr]   <= d_pc;
            mem_err[wptr]  <= HRESP;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= RUN;
            htrans_q   <= TR_IDLE;
            haddr_q    <= RESET_PC;
            next_pc    <= RESET_PC;
            flush_pend <= 1'b0;
            flush_pc   <= RESET_PC;
            d_valid    <= 1'b0;
            d_disc     <= 1'b0;
            d_pc       <= RESET_PC;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            count <= count_n;
            if (flush_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr)  wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
            end

            if (HREADY) begin
                d_valid <= a_valid;
                d_pc    <= haddr_q;
                d_disc  <= flush_i || flush_pend || wr_err;
            end else if (flush_i) begin
                d_disc <= 1'b1;
            end

            if (HREADY) begin
                if (issue) begin
                    htrans_q   <= nonseq_n ? TR_NONSEQ : TR_SEQ;
                    haddr_q    <= tgt_pc;
                    next_pc    <= tgt_pc + BYTES;
                    flush_pend <= 1'b0;
                end else begin
                    htrans_q <= TR_IDLE;
                    if (flush_i) begin
                        flush_pend <= 1'b1;
                        flush_pc   <= flush_pc_i;
                    end
                end
            end else begin
                if (err_first) htrans_q <= TR_IDLE;
                if (flush_i) begin
                    flush_pend <= 1'b1;
                    flush_pc   <= flush_pc_i;
                end
            end

            if (flush_i)
                state <= RUN;
            else if (err_first || wr_err)
                state <= ERR;
            else if (state != ERR && HREADY)
                state <= issue ? RUN : HOLD;
        end
    end
endmodule

// File: tb/tb_ahb3lite_ifetch.sv
// Randomized scoreboard bench for ahb3lite_ifetch: AHB slave model, stream reference model, bus rule checker.
module tb_ahb3lite_ifetch;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [31:0] HADDR, HWDATA, HRDATA, flush_pc_i, inst_o, inst_pc_o;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP, flush_i, inst_ready_i, inst_err_o, inst_valid_o;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb3lite_ifetch #(.HADDR_SIZE(32), .HDATA_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i));

    typedef struct packed {logic [31:0] pc; logic [31:0] data; logic err;} ent_t;
    ent_t        exp_q[$];
    ent_t        mon_e;
    int          n_chk = 0, n_pass = 0;
    int          wait_max = 0, acc_cnt = 0;
    logic        err_en = 1'b0, err_seen = 1'b0;
    logic [31:0] err_addr = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    // Reference: after a redirect the consumer sees consecutive words from the
    // target; an erroring address yields one err entry and ends the stream.
    task automatic build_stream(input logic [31:0] t);
        ent_t e;
        exp_q.delete();
        err_seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            e.pc = t + 32'(i) * 4;
            if (err_en && e.pc == err_addr) begin
                e.data = '0; e.err = 1'b1;
                exp_q.push_back(e);
                break;
            end
            e.data = memf(e.pc); e.err = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Slave model: captures bus state before each edge, drives the next cycle after it.
    logic [1:0]  cap_trans = T_IDLE;
    logic [31:0] cap_addr = 32'h0, sv_addr = 32'h0;
    logic        cap_rdy = 1'b1, sv_active = 1'b0, sv_err = 1'b0, sv_stage = 1'b0;
    int          sv_wait = 0;
    initial begin HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; end
    always @(negedge HCLK) begin cap_trans = HTRANS; cap_addr = HADDR; cap_rdy = HREADY; end
    always @(posedge HCLK) begin
        #1;
        if (!HRESETn) sv_active = 1'b0;
        else if (cap_rdy) begin
            sv_active = cap_trans[1]; sv_addr = cap_addr;
            sv_wait = $urandom_range(0, wait_max);
            sv_err = err_en && (cap_addr == err_addr); sv_stage = 1'b0;
        end
        HRDATA = 32'hDEAD_BEEF;
        if (!sv_active) begin HREADY = 1'b1; HRESP = 1'b0; end
        else if (sv_wait > 0) begin HREADY = 1'b0; HRESP = 1'b0; sv_wait--; end
        else if (sv_err) begin
            HRESP = 1'b1; HREADY = sv_stage; sv_stage = 1'b1;
        end else begin HREADY = 1'b1; HRESP = 1'b0; HRDATA = memf(sv_addr); end
    end

    // Scoreboard monitor: compares every pop against the reference queue.
    always @(negedge HCLK) begin
        if (HRESETn && inst_valid_o && inst_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL extra_pop actual_pc=%0h required=none", inst_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", inst_pc_o, mon_e.pc);
                chk("pop_data", inst_o, mon_e.data);
                chk("pop_err", inst_err_o, mon_e.err);
                if (inst_err_o) err_seen = 1'b1;
            end
        end
    end

    // Bus rule checker.
    logic [1:0]  p_trans = T_IDLE;
    logic [31:0] p_addr = 32'h0;
    logic        p_rdy = 1'b1, p_resp = 1'b0;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            p_trans = T_IDLE; p_rdy = 1'b1; p_resp = 1'b0;
        end else begin
            if (HTRANS[1] && HREADY) acc_cnt++;
            if (!p_rdy && p_trans[1] && !p_resp) begin
                chk("hold_trans", HTRANS, p_trans);
                chk("hold_addr", HADDR, p_addr);
            end else if (p_rdy && HTRANS == T_SEQ) begin
                chk("seq_follows", p_trans[1], 1'b1);
                chk("seq_addr", HADDR, p_addr + 32'd4);
            end
            if (HTRANS[1] && HADDR[9:0] == 10'd0) chk("kb_nonseq", HTRANS, T_NONSEQ);
            if (HTRANS == 2'b01) chk("not_busy", HTRANS, T_IDLE);
            if (err_seen && !flush_i) chk("idle_after_err", HTRANS, T_IDLE);
            p_trans = HTRANS; p_addr = HADDR; p_rdy = HREADY; p_resp = HRESP;
        end
    end

    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    task automatic flush_to(input logic [31:0] t);
        flush_i = 1'b1; flush_pc_i = t;
        build_stream(t);
        tick();
        flush_i = 1'b0; flush_pc_i = $urandom;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0; flush_i = 1'b0; inst_ready_i = 1'b0;
        exp_q.delete(); err_seen = 1'b0;
        repeat (3) tick();
        chk("rst_htrans", HTRANS, T_IDLE);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_err", inst_err_o, 1'b0);
        chk("rst_consts", {HWRITE, HSIZE, HBURST, HPROT, HWDATA}, {1'b0, 3'd2, 3'b001, 4'b0000, 32'h0});
        HRESETn = 1'b1;
        build_stream(32'h0);
    endtask

    int          a;
    logic        got1, got2;
    logic [31:0] tgt;

    initial begin
        flush_i = 1'b0; flush_pc_i = 32'h0; inst_ready_i = 1'b0;

        wait_max = 0; err_en = 1'b0;
        do_reset();
        inst_ready_i = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        chk("start_nonseq", {HTRANS, HADDR}, {T_NONSEQ, 32'h0});
        @(negedge HCLK);
        chk("start_seq4", {HTRANS, HADDR}, {T_SEQ, 32'h4});
        @(negedge HCLK);
        chk("start_pc0", {inst_valid_o, inst_pc_o}, {1'b1, 32'h0});
        @(negedge HCLK);
        chk("start_pc4", {inst_valid_o, inst_pc_o}, {1'b1, 32'h4});
        tick();

        do_reset();
        a = acc_cnt;
        repeat (20) tick();
        chk("credit_fill", acc_cnt - a, 4);
        chk("fill_valid", inst_valid_o, 1'b1);
        a = acc_cnt;
        inst_ready_i = 1'b1; tick(); inst_ready_i = 1'b0;
        repeat (15) tick();
        chk("credit_one", acc_cnt - a, 1);
        inst_ready_i = 1'b1;
        repeat (10) tick();

        wait_max = 2;
        repeat (5) tick();
        flush_to(32'h100);
        chk("flush_empty", inst_valid_o, 1'b0);
        got1 = 1'b0;
        for (int i = 0; i < 40 && !got1; i++) begin
            if (inst_valid_o) begin chk("flush_first_pc", inst_pc_o, 32'h100); got1 = 1'b1; end
            else tick();
        end
        chk("flush_seen", got1, 1'b1);
        repeat (10) tick();

        wait_max = 0; err_en = 1'b1; err_addr = 32'h8;
        do_reset();
        inst_ready_i = 1'b1;
        repeat (30) tick();
        chk("err_drained", exp_q.size(), 0);
        a = acc_cnt;
        repeat (20) tick();
        chk("err_no_fetch", acc_cnt - a, 0);
        chk("err_idle", HTRANS, T_IDLE);
        err_en = 1'b0;
        flush_to(32'h200);
        repeat (20) tick();

        flush_to(32'h3F0);
        got1 = 1'b0; got2 = 1'b0;
        for (int i = 0; i < 40 && !(got1 && got2); i++) begin
            @(negedge HCLK);
            if (!got1 && HTRANS[1] && HADDR == 32'h3FC) begin chk("kb_3fc_seq", HTRANS, T_SEQ); got1 = 1'b1; end
            if (!got2 && HTRANS[1] && HADDR == 32'h400) begin chk("kb_400_nonseq", HTRANS, T_NONSEQ); got2 = 1'b1; end
        end
        chk("kb_seen", {got1, got2}, 2'b11);
        tick();

        for (int ph = 0; ph < 30; ph++) begin
            wait_max = $urandom_range(0, 3);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 : 32'($urandom_range(0, 4095)) << 2;
            err_en = ($urandom_range(0, 2) == 0);
            err_addr = tgt + 32'($urandom_range(0, 12)) * 4;
            flush_to(tgt);
            for (int c = 0; c < 60; c++) begin
                inst_ready_i = ($urandom_range(0, 3) != 0);
                if (ph == 20 && c == 30) begin
                    do_reset();
                    inst_ready_i = 1'b1;
                end else if ($urandom_range(0, 40) == 0)
                    flush_to(32'($urandom_range(0, 4095)) << 2);
                else
                    tick();
            end
        end

        inst_ready_i = 1'b1;
        repeat (30) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb3lite_ifetch.md
AHB3LITE_IFETCH -- requirements
Module: ahb3lite_ifetch

Interface
REQ-001 Parameter HADDR_SIZE, 32, AHB address width.
REQ-002 Parameter HDATA_SIZE, 32, AHB data and instruction width.
REQ-003 Parameter DEPTH, 4, prefetch buffer entries (power of 2, >=2).
REQ-004 Parameter RESET_PC, 'h0, first fetch address after reset.
REQ-005 HCLK  in  1  clock, rising edge.
REQ-006 HRESETn  in  1  reset, asynchronous, active-low.
REQ-007 HADDR  out  HADDR_SIZE  AHB master address.
REQ-008 HTRANS  out  2  IDLE/NONSEQ/SEQ; never BUSY.
REQ-009 HWRITE  out  1  constant 0.
REQ-010 HSIZE  out  3  constant word, log2(HDATA_SIZE/8).
REQ-011 HBURST  out  3  constant INCR.
REQ-012 HPROT  out  4  constant 4'b0000 (opcode, user, non-bufferable, non-cacheable).
REQ-013 HWDATA  out  HDATA_SIZE  constant 0.
REQ-014 HRDATA  in  HDATA_SIZE  read data.
REQ-015 HREADY  in  1  transfer complete / bus ready.
REQ-016 HRESP  in  1  0=OKAY, 1=ERROR.
REQ-017 flush_i  in  1  redirect request; flush_pc_i is valid only in the same cycle.
REQ-018 flush_pc_i  in  HADDR_SIZE  redirect target, word aligned.
REQ-019 inst_o, inst_pc_o, inst_err_o  out  HDATA_SIZE/HADDR_SIZE/1  head-of-buffer instruction, its address, bus-error flag.
REQ-020 inst_valid_o / inst_ready_i  out/in  1  consumer handshake; a pop occurs when both are 1.

Function
REQ-021 Fetch is pipelined per AHB: address phase, then data phase completing in the first cycle HREADY=1; at most one address phase and one data phase are outstanding.
REQ-022 New address issue only when HREADY=1 and (buffer count + outstanding data phases) < DEPTH; otherwise HTRANS=IDLE.
REQ-023 First transfer after reset, after a flush, after an IDLE gap, or at a 1KB boundary crossing is NONSEQ; consecutive transfers are SEQ, with HADDR += HDATA_SIZE/8.
REQ-024 HADDR and HTRANS hold stable while HREADY=0 during an accepted address phase.
REQ-025 FSM states: RUN (fetching), HOLD (credit exhausted, HTRANS=IDLE), ERR (fetching stopped).
REQ-026 Transitions: RUN->HOLD when no credit; HOLD->RUN when credit frees; any state->ERR on an ERROR data phase; ERR->RUN only on flush_i.
REQ-027 The buffer is a FIFO of DEPTH entries {data, pc, err}; it is written on each non-discarded data phase completion with HREADY=1.
REQ-028 inst_valid_o = buffer not empty; inst_o, inst_pc_o and inst_err_o show the head entry.
REQ-029 Pop and write may occur in the same cycle; the count then stays unchanged; count never exceeds DEPTH.
REQ-030 An ERROR response (first cycle HRESP=1, HREADY=0) drives HTRANS=IDLE in the following cycle, per the two-cycle response.
REQ-031 An ERROR response writes one entry with err=1 and data=0; subsequent responses are discarded.
REQ-032 flush_i empties the buffer in the same clock edge, and inst_valid_o=0 next cycle.
REQ-033 Outstanding data phases at the time of the flush are completed on the bus but marked discard and never written.
REQ-034 After flush, the next address phase is NONSEQ at flush_pc_i; it issues in the first cycle with HREADY=1 and no address phase pending.
REQ-035 If flush_i and a pop occur in the same cycle, the flush wins.
REQ-036 If flush_i asserts during a held address phase, the target is latched and the pending address completes unchanged.
REQ-037 A second flush_i before the redirect issues overwrites the latched target.
REQ-038 The pc counter wraps modulo 2^HADDR_SIZE.

Reset
REQ-039 On HRESETn low: HTRANS=IDLE, HADDR=RESET_PC, FIFO empty, inst_valid_o=0, inst_err_o=0, state RUN, discard flags cleared, no outstanding transfers.
REQ-040 First NONSEQ to RESET_PC in the first cycle after reset release with HREADY=1.
REQ-041 Asserting reset mid-transfer abandons all state with no partial writes.

Verification
REQ-042 Reset, RESET_PC=0, HREADY=1, zero-wait slave, inst_ready_i=1 -> NONSEQ 0x0, SEQ 0x4, 0x8...; inst_pc_o 0,4,8 on consecutive cycles from cycle 3.
REQ-043 inst_ready_i=0, DEPTH=4 -> exactly 4 transfers, then HTRANS=IDLE; one pop -> exactly one new SEQ/NONSEQ issued.
REQ-044 flush_i with flush_pc_i=0x100 while a data phase is outstanding -> that data is dropped, next transfer NONSEQ 0x100, first inst_pc_o=0x100.
REQ-045 Slave inserts 2 wait states on 0x8 -> HADDR=0xC held stable for both cycles, ordering preserved.
REQ-046 ERROR response on 0x8 -> entry 0x8 has inst_err_o=1, HTRANS=IDLE, no further fetches until flush_i.
REQ-047 Fetch from 0x3F8 -> 0x3FC is SEQ, 0x400 is NONSEQ.
